xor_frame_checksum: RTL and testbench

- Streaming XOR checksum engine, the parametrised sequential successor to the team's single-bit XOR gate.
- Accepts a frame of WIDTH-bit words over a valid/ready handshake and folds them into a running XOR.
- On the last word it presents checksum, parity, word count, overflow flag and optional compare result, holding them until the consumer accepts.
- Sits between a word source and a checker/logger in the team's test designs.

---
 rtl/xor_frame_checksum_pkg.sv | 25 ++
 rtl/xor_word_acc.sv | 53 +++++
 rtl/xor_frame_checksum.sv | 100 ++++++++++
 tb/tb_xor_frame_checksum.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/xor_frame_checksum_pkg.sv
// Shared definitions for the XOR frame checksum engine: FSM encoding and a
// constant-width helper for parametrised counters.
package xor_frame_checksum_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Bits needed to index 'value' distinct states (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/xor_word_acc.sv
// Running XOR accumulator with a saturating word counter and sticky overflow.
// Outputs are the would-be updated values, so the parent can latch a result on the last word.
module xor_word_acc
    import xor_frame_checksum_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] acc_nxt_o,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             ovf_nxt_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        acc_d = acc_q ^ data_i;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (cnt_q < CNT_W'(MAX_WORDS)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            ovf_d = 1'b1;
        end
    end

    // Clear wins over enable: the last word of a frame is folded into the
    // parent's output registers, not into the next frame.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_nxt_o = acc_d;
    assign cnt_nxt_o = cnt_d;
    assign ovf_nxt_o = ovf_d;

endmodule

// File: rtl/xor_frame_checksum.sv
// Streaming XOR checksum: folds a valid/ready frame of words into one result
// (sum, parity, count, overflow, compare) held until the consumer accepts it.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_ACCUM | accepting words, in_ready=1
//   ST_HOLD  | result presented on out_*, waiting for out_ready
module xor_frame_checksum
    import xor_frame_checksum_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_WORDS = 16,
    localparam int CNT_W     = clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             chk_en,
    input  logic [WIDTH-1:0] chk_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_match,
    output logic             out_overflow
);

    state_t           state_q, state_d;
    logic             accept;
    logic             frame_done;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;
    logic             par_d, par_q;
    logic             match_d, match_q;

    assign in_ready   = (state_q == ST_ACCUM);
    assign out_valid  = (state_q == ST_HOLD);
    assign accept     = in_valid && in_ready;
    assign frame_done = accept && in_last;

    xor_word_acc #(
        .WIDTH     (WIDTH),
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (frame_done),
        .en_i      (accept),
        .data_i    (in_data),
        .acc_nxt_o (sum_d),
        .cnt_nxt_o (cnt_d),
        .ovf_nxt_o (ovf_d)
    );

    assign par_d   = ^sum_d;
    assign match_d = chk_en && (sum_d == chk_value);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (frame_done) state_d = ST_HOLD;
            ST_HOLD:  if (out_ready)  state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            par_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (frame_done) begin
                sum_q   <= sum_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
                par_q   <= par_d;
                match_q <= match_d;
            end
        end
    end

    assign out_sum      = sum_q;
    assign out_parity   = par_q;
    assign out_count    = cnt_q;
    assign out_match    = match_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench: three configurations (8-bit/16, 8-bit/4, 1-bit/16) share one
// handshake stream, so each scenario is checked on whichever instance it targets.
module tb_xor_frame_checksum;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_last, chk_en, out_ready;
    logic [7:0] in_data, chk_value;

    logic       a_ready, a_ovalid, a_par, a_match, a_ovf;
    logic [7:0] a_sum;
    logic [4:0] a_cnt;
    logic       b_ready, b_ovalid, b_par, b_match, b_ovf;
    logic [7:0] b_sum;
    logic [2:0] b_cnt;
    logic       c_ready, c_ovalid, c_par, c_match, c_ovf;
    logic [0:0] c_sum;
    logic [4:0] c_cnt;

    xor_frame_checksum #(.WIDTH(8), .MAX_WORDS(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready),
        .in_data(in_data), .in_last(in_last), .chk_en(chk_en), .chk_value(chk_value),
        .out_valid(a_ovalid), .out_ready(out_ready), .out_sum(a_sum), .out_parity(a_par),
        .out_count(a_cnt), .out_match(a_match), .out_overflow(a_ovf)
    );

    xor_frame_checksum #(.WIDTH(8), .MAX_WORDS(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready),
        .in_data(in_data), .in_last(in_last), .chk_en(chk_en), .chk_value(chk_value),
        .out_valid(b_ovalid), .out_ready(out_ready), .out_sum(b_sum), .out_parity(b_par),
        .out_count(b_cnt), .out_match(b_match), .out_overflow(b_ovf)
    );

    xor_frame_checksum #(.WIDTH(1), .MAX_WORDS(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ready),
        .in_data(in_data[0:0]), .in_last(in_last), .chk_en(chk_en), .chk_value(chk_value[0:0]),
        .out_valid(c_ovalid), .out_ready(out_ready), .out_sum(c_sum), .out_parity(c_par),
        .out_count(c_cnt), .out_match(c_match), .out_overflow(c_ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; drops in_valid after the accepting edge.
    task automatic send(input logic [7:0] d, input logic last, input logic ce, input logic [7:0] cv);
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        chk_en    = ce;
        chk_value = cv;
        n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", a_ovalid, 1'b0);
    endtask

    typedef struct {
        int          n;
        logic [31:0] w;
        logic        ce;
        logic [7:0]  cv;
        logic [7:0]  sum;
        logic        par;
        logic [4:0]  cnt;
        logic        match;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        logic       sum;
    } bit_vec_t;

    vec_t       tbl[5];
    bit_vec_t   btbl[4];

    initial begin
        logic [31:0] wv;

        tbl[0] = '{3, 32'h003CF00F, 1'b0, 8'h00, 8'hC3, 1'b0, 5'd3, 1'b0, 1'b0};
        tbl[1] = '{1, 32'h000000A5, 1'b1, 8'hA5, 8'hA5, 1'b0, 5'd1, 1'b1, 1'b0};
        tbl[2] = '{1, 32'h000000A5, 1'b1, 8'hA4, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0};
        tbl[3] = '{2, 32'h00000181, 1'b1, 8'h80, 8'h80, 1'b1, 5'd2, 1'b1, 1'b0};
        tbl[4] = '{4, 32'h08040201, 1'b0, 8'h0F, 8'h0F, 1'b0, 5'd4, 1'b0, 1'b0};

        btbl[0] = '{8'h00, 8'h00, 1'b0};
        btbl[1] = '{8'h01, 8'h00, 1'b1};
        btbl[2] = '{8'h00, 8'h01, 1'b1};
        btbl[3] = '{8'h01, 8'h01, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; chk_en = 1'b0;
        out_ready = 1'b0; in_data = 8'h00; chk_value = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_valid", a_ovalid, 1'b0);
        check("rst_ready", a_ready, 1'b1);
        check("rst_sum", a_sum, 8'h00);
        check("rst_cnt", a_cnt, 5'd0);
        check("rst_ovf", a_ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Main function: table of frames on the 8-bit / 16-word instance.
        for (int k = 0; k < 5; k++) begin
            wv = tbl[k].w;
            for (int i = 0; i < tbl[k].n; i++)
                send(wv[8*i +: 8], (i == tbl[k].n - 1), tbl[k].ce, tbl[k].cv);
            check($sformatf("v%0d_valid", k), a_ovalid, 1'b1);
            check($sformatf("v%0d_ready", k), a_ready, 1'b0);
            check($sformatf("v%0d_sum", k), a_sum, tbl[k].sum);
            check($sformatf("v%0d_par", k), a_par, tbl[k].par);
            check($sformatf("v%0d_cnt", k), a_cnt, tbl[k].cnt);
            check($sformatf("v%0d_match", k), a_match, tbl[k].match);
            check($sformatf("v%0d_ovf", k), a_ovf, tbl[k].ovf);
            release_result();
        end

        // Backpressure: held result, pending word waits for ACCUM.
        send(8'hC3, 1'b1, 1'b0, 8'h00);
        in_valid = 1'b1; in_data = 8'h11; in_last = 1'b1; chk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", a_ready, 1'b0);
            check("bp_valid", a_ovalid, 1'b1);
            check("bp_sum", a_sum, 8'hC3);
            check("bp_cnt", a_cnt, 5'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_bubble_valid", a_ovalid, 1'b0);
        check("bp_bubble_ready", a_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_next_valid", a_ovalid, 1'b1);
        check("bp_next_sum", a_sum, 8'h11);
        check("bp_next_cnt", a_cnt, 5'd1);
        release_result();

        // Overflow on the 4-word instance; the 16-word one just counts.
        for (int i = 0; i < 5; i++) send(8'h01, (i == 4), 1'b0, 8'h00);
        check("ovf_b_cnt", b_cnt, 3'd4);
        check("ovf_b_flag", b_ovf, 1'b1);
        check("ovf_b_sum", b_sum, 8'h01);
        check("ovf_b_par", b_par, 1'b1);
        check("ovf_a_cnt", a_cnt, 5'd5);
        check("ovf_a_flag", a_ovf, 1'b0);
        release_result();
        send(8'h02, 1'b1, 1'b0, 8'h00);
        check("ovf_clr_flag", b_ovf, 1'b0);
        check("ovf_clr_cnt", b_cnt, 3'd1);
        check("ovf_clr_sum", b_sum, 8'h02);
        release_result();
        for (int i = 0; i < 4; i++) send(8'h01, (i == 3), 1'b0, 8'h00);
        check("full_b_cnt", b_cnt, 3'd4);
        check("full_b_flag", b_ovf, 1'b0);
        check("full_b_sum", b_sum, 8'h00);
        release_result();

        // Reset mid-frame discards the partial frame.
        send(8'h12, 1'b0, 1'b0, 8'h00);
        send(8'h34, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(8'h55, 1'b1, 1'b0, 8'h00);
        check("rstf_sum", a_sum, 8'h55);
        check("rstf_cnt", a_cnt, 5'd1);
        release_result();

        // Reset mid-hold clears every output.
        send(8'hA5, 1'b1, 1'b1, 8'hA5);
        check("rsth_pre_match", a_match, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rsth_valid", a_ovalid, 1'b0);
        check("rsth_sum", a_sum, 8'h00);
        check("rsth_par", a_par, 1'b0);
        check("rsth_cnt", a_cnt, 5'd0);
        check("rsth_match", a_match, 1'b0);
        check("rsth_ovf", a_ovf, 1'b0);
        check("rsth_ready", a_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // 1-bit truth table on two-word frames.
        for (int k = 0; k < 4; k++) begin
            send(btbl[k].w0, 1'b0, 1'b0, 8'h00);
            send(btbl[k].w1, 1'b1, 1'b0, 8'h00);
            check($sformatf("w1_%0d_valid", k), c_ovalid, 1'b1);
            check($sformatf("w1_%0d_sum", k), c_sum, btbl[k].sum);
            check($sformatf("w1_%0d_par", k), c_par, btbl[k].sum);
            check($sformatf("w1_%0d_cnt", k), c_cnt, 5'd2);
            release_result();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
